bios_stream_bridge: RTL and testbench

BIOS_STREAM_BRIDGE -- requirements
Module: bios_stream_bridge

---
 rtl/bios_stream_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_bios_stream_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bios_stream_bridge.sv
// rtl/bios_stream_bridge.sv - download byte stream to 16-bit pull-side BIOS word bridge, 64x16 ping-pong buffer.
// Optional checksum accumulator: define BIOS_BRIDGE_CHECKSUM_EN.
module bios_stream_bridge #(
    parameter logic [7:0] BIOS_INDEX = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        bios_req,
    output logic [12:0] bios_addr,
    output logic [15:0] bios_din,
    output logic        bios_wr,
    output logic        bios_loaded,
    output logic        overflow,
    output logic [15:0] checksum
);

    logic [15:0] mem [0:63];

    logic        dl_q, dl_d;
    logic        armed_q, armed_d;
    logic        done_q, done_d;
    logic        pull_seen_q, pull_seen_d;
    logic        overflow_q, overflow_d;
    logic        loaded_q, loaded_d;
    logic        end_valid_q, end_valid_d;
    logic        partial_q, partial_d;
    logic [1:0]  full_q, full_d;
    logic [5:0]  rd_ptr_q, rd_ptr_d;
    logic [5:0]  end_ptr_q, end_ptr_d;
    logic [5:0]  wr_last_q, wr_last_d;
    logic [7:0]  lo_q, lo_d;
    logic [12:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;

    logic        dl_rise, dl_fall, accept, word_wr, wr_ok, pull, at_end;
    logic [1:0]  full_base;
    logic [15:0] rd_word;

    // Address bits between the buffer index and the range check carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^ioctl_addr[13:7];

    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q & armed_q;
    assign accept    = ioctl_download & ioctl_wr & (ioctl_index == BIOS_INDEX) & (armed_q | dl_rise);
    assign word_wr   = accept & ioctl_addr[0];
    assign full_base = dl_rise ? 2'b00 : full_q;
    assign wr_ok     = word_wr & ~full_base[ioctl_addr[6]] & (ioctl_addr[24:14] == 11'd0);
    assign pull      = bios_req & full_q[rd_ptr_q[5]] & ~dl_rise;
    assign at_end    = end_valid_q & (rd_ptr_q == end_ptr_q);
    assign rd_word   = mem[rd_ptr_q];

    always_ff @(posedge clk_sys) begin
        if (wr_ok) begin
            mem[ioctl_addr[6:1]] <= {ioctl_dout, lo_q};
        end
    end

    always_comb begin
        dl_d        = ioctl_download;
        armed_d     = armed_q;
        done_d      = done_q;
        pull_seen_d = pull_seen_q;
        overflow_d  = overflow_q;
        loaded_d    = loaded_q;
        end_valid_d = end_valid_q;
        partial_d   = partial_q;
        full_d      = full_base;
        rd_ptr_d    = rd_ptr_q;
        end_ptr_d   = end_ptr_q;
        wr_last_d   = wr_last_q;
        lo_d        = lo_q;
        addr_d      = addr_q;
        din_d       = din_q;

        if (dl_rise) begin
            armed_d     = 1'b1;
            done_d      = 1'b0;
            pull_seen_d = 1'b0;
            loaded_d    = 1'b0;
            end_valid_d = 1'b0;
            partial_d   = 1'b0;
            rd_ptr_d    = '0;
            addr_d      = '0;
        end else if (done_q && full_q == 2'b00) begin
            loaded_d = 1'b1;
        end

        if (pull) begin
            din_d       = rd_word;
            rd_ptr_d    = rd_ptr_q + 6'd1;
            addr_d      = pull_seen_q ? addr_q + 13'd1 : 13'd0;
            pull_seen_d = 1'b1;
            // Leaving a half (natural boundary or truncated end) hands it back to the writer.
            if (rd_ptr_q[4:0] == 5'd31 || at_end) begin
                full_d[rd_ptr_q[5]] = 1'b0;
            end
            if (at_end) begin
                end_valid_d = 1'b0;
            end
        end

        if (accept && !ioctl_addr[0]) begin
            lo_d = ioctl_dout;
        end

        if (word_wr) begin
            if (wr_ok) begin
                wr_last_d = ioctl_addr[6:1];
                if (ioctl_addr[5:1] == 5'd31) begin
                    full_d[ioctl_addr[6]] = 1'b1;
                    partial_d             = 1'b0;
                end else begin
                    partial_d = 1'b1;
                end
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (dl_fall) begin
            armed_d = 1'b0;
            done_d  = 1'b1;
            if (partial_q) begin
                full_d[wr_last_q[5]] = 1'b1;
                end_ptr_d            = wr_last_q;
                end_valid_d          = 1'b1;
                partial_d            = 1'b0;
            end
        end
    end

    // dl_q resets high so a download still active across reset cannot re-arm the bridge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q        <= 1'b1;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
            pull_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            loaded_q    <= 1'b0;
            end_valid_q <= 1'b0;
            partial_q   <= 1'b0;
            full_q      <= '0;
            rd_ptr_q    <= '0;
            end_ptr_q   <= '0;
            wr_last_q   <= '0;
            lo_q        <= '0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            dl_q        <= dl_d;
            armed_q     <= armed_d;
            done_q      <= done_d;
            pull_seen_q <= pull_seen_d;
            overflow_q  <= overflow_d;
            loaded_q    <= loaded_d;
            end_valid_q <= end_valid_d;
            partial_q   <= partial_d;
            full_q      <= full_d;
            rd_ptr_q    <= rd_ptr_d;
            end_ptr_q   <= end_ptr_d;
            wr_last_q   <= wr_last_d;
            lo_q        <= lo_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

`ifdef BIOS_BRIDGE_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (dl_rise) begin
            sum_d = '0;
        end else if (pull) begin
            sum_d = sum_q + rd_word;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign bios_addr   = addr_q;
    assign bios_din    = din_q;
    assign bios_wr     = full_q[rd_ptr_q[5]];
    assign bios_loaded = loaded_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_bios_stream_bridge.sv
// tb/tb_bios_stream_bridge.sv - directed self-checking bench for bios_stream_bridge.
module tb_bios_stream_bridge;

    localparam logic [7:0] IDX = 8'h05;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        bios_req;
    logic [12:0] bios_addr;
    logic [15:0] bios_din;
    logic        bios_wr;
    logic        bios_loaded;
    logic        overflow;
    logic [15:0] checksum;

    int n_checks = 0;
    int n_errors = 0;

    bios_stream_bridge #(.BIOS_INDEX(IDX)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .bios_req       (bios_req),
        .bios_addr      (bios_addr),
        .bios_din       (bios_din),
        .bios_wr        (bios_wr),
        .bios_loaded    (bios_loaded),
        .overflow       (overflow),
        .checksum       (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bval(input int i, input int mul, input int add);
        return 8'((i * mul + add) & 255);
    endfunction

    task automatic wr_byte(input int a, input logic [7:0] d, input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_wr    = 1'b1;
        ioctl_addr  = 25'(a);
        ioctl_dout  = d;
        ioctl_index = idx;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic write_stream(input int nbytes, input int mul, input int add, input logic [7:0] idx);
        for (int i = 0; i < nbytes; i++) wr_byte(i, bval(i, mul, add), idx);
    endtask

    task automatic dl_start;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic dl_end;
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic pull_word(output logic [15:0] d, output logic [12:0] a);
        @(negedge clk_sys);
        bios_req = 1'b1;
        @(negedge clk_sys);
        bios_req = 1'b0;
        d = bios_din;
        a = bios_addr;
    endtask

    // Drains up to 'limit' words, checking each against the byte pattern.
    task automatic drain(input string tag, input int limit, input int mul, input int add, output int count);
        logic [15:0] d;
        logic [12:0] a;
        count = 0;
        while (bios_wr && count < limit) begin
            pull_word(d, a);
            check({tag, "_data"}, 64'(d), 64'({bval(2 * count + 1, mul, add), bval(2 * count, mul, add)}));
            check({tag, "_addr"}, 64'(a), 64'(count));
            count++;
        end
    endtask

    initial begin
        int          cnt;
        logic [15:0] exp_sum;
        logic [15:0] hold_din;
        logic [12:0] hold_addr;
        logic [15:0] d;
        logic [12:0] a;

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        bios_req       = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("reset_outputs", {bios_addr, bios_din, bios_wr, bios_loaded, overflow, checksum}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Wrong index: nothing accepted.
        dl_start();
        write_stream(128, 1, 0, IDX + 8'd1);
        check("wrong_index_wr", 64'(bios_wr), 64'd0);
        check("wrong_index_ovf", 64'(overflow), 64'd0);
        dl_end();

        // Full 128-byte stream 0x00..0x7F.
        dl_start();
        check("start_loaded_clr", 64'(bios_loaded), 64'd0);
        write_stream(128, 1, 0, IDX);
        dl_end();
        check("full_wr_ready", 64'(bios_wr), 64'd1);
        check("full_not_loaded", 64'(bios_loaded), 64'd0);
        drain("full", 64, 1, 0, cnt);
        check("full_count", 64'(cnt), 64'd64);
        check("full_wr_after", 64'(bios_wr), 64'd0);
        repeat (2) @(negedge clk_sys);
        check("full_loaded", 64'(bios_loaded), 64'd1);
        exp_sum = '0;
`ifdef BIOS_BRIDGE_CHECKSUM_EN
        for (int k = 0; k < 64; k++) exp_sum = exp_sum + {bval(2 * k + 1, 1, 0), bval(2 * k, 1, 0)};
`endif
        check("checksum", 64'(checksum), 64'(exp_sum));

        // Pull strobes with nothing available are ignored.
        hold_din  = bios_din;
        hold_addr = bios_addr;
        @(negedge clk_sys);
        bios_req = 1'b1;
        repeat (4) @(negedge clk_sys);
        bios_req = 1'b0;
        check("idle_req_din", 64'(bios_din), 64'(hold_din));
        check("idle_req_addr", 64'(bios_addr), 64'(hold_addr));

        // 70-byte stream ending mid-half.
        dl_start();
        write_stream(70, 3, 5, IDX);
        dl_end();
        drain("short", 100, 3, 5, cnt);
        check("short_count", 64'(cnt), 64'd35);
        check("short_wr_after", 64'(bios_wr), 64'd0);
        repeat (2) @(negedge clk_sys);
        check("short_loaded", 64'(bios_loaded), 64'd1);
        check("short_no_ovf", 64'(overflow), 64'd0);

        // 96 words with no pulls: the last 32 are dropped.
        dl_start();
        write_stream(192, 7, 1, IDX);
        check("over_flag", 64'(overflow), 64'd1);
        dl_end();
        drain("over", 100, 7, 1, cnt);
        check("over_count", 64'(cnt), 64'd64);
        repeat (2) @(negedge clk_sys);
        check("over_loaded", 64'(bios_loaded), 64'd1);

        // Reset in the middle of a download with live outputs.
        dl_start();
        write_stream(64, 1, 9, IDX);
        pull_word(d, a);
        pull_word(d, a);
        check("mid_pre_addr", 64'(a), 64'd1);
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        check("mid_reset_outputs", {bios_addr, bios_din, bios_wr, bios_loaded, overflow, checksum}, 64'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        write_stream(64, 1, 9, IDX);
        check("post_reset_ignored", 64'(bios_wr), 64'd0);
        dl_end();
        check("post_reset_not_loaded", 64'(bios_loaded), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
